// File: rtl/letter_pool.sv
// letter_pool: pool of falling letters for the typing game. Each frame it sweeps, spawns and resolves typed keys.
// Optional difficulty ramp on spawned speed, enabled by defining LETTER_POOL_RAMP_EN.

module letter_pool_slot #(
  parameter int X_MAX = 480
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       sweep_en,
  input  logic       ld_en,
  input  logic       clr_en,
  input  logic [7:0] ld_ch,
  input  logic [3:0] ld_speed,
  input  logic [8:0] ld_x,
  input  logic [9:0] ld_y,
  input  logic [7:0] key_ch,
  output logic       active,
  output logic [7:0] ch,
  output logic [8:0] x,
  output logic [9:0] y,
  output logic       over,
  output logic       match
);
  logic       active_q, active_d;
  logic [7:0] ch_q, ch_d;
  logic [8:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [3:0] speed_q, speed_d;
  logic [9:0] sum;

  always_comb begin
    sum      = {1'b0, x_q} + {6'b0, speed_q};
    over     = active_q && (sum >= 10'(X_MAX));
    match    = active_q && (ch_q == key_ch);
    active_d = active_q;
    ch_d     = ch_q;
    x_d      = x_q;
    y_d      = y_q;
    speed_d  = speed_q;
    if (ld_en) begin
      active_d = 1'b1;
      ch_d     = ld_ch;
      x_d      = ld_x;
      y_d      = ld_y;
      speed_d  = ld_speed;
    end else if (clr_en) begin
      active_d = 1'b0;
    end else if (sweep_en && active_q) begin
      if (over) active_d = 1'b0;
      else      x_d      = sum[8:0];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      active_q <= 1'b0;
      ch_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      speed_q  <= '0;
    end else begin
      active_q <= active_d;
      ch_q     <= ch_d;
      x_q      <= x_d;
      y_q      <= y_d;
      speed_q  <= speed_d;
    end
  end

  assign active = active_q;
  assign ch     = ch_q;
  assign x      = x_q;
  assign y      = y_q;
endmodule

module letter_pool #(
  parameter int SLOTS        = 8,
  parameter int IDXW         = 3,
  parameter int X_MAX        = 480,
  parameter int SPAWN_PERIOD = 30
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            frame_tick,
  input  logic [7:0]      gen_ch,
  input  logic [3:0]      gen_speed,
  input  logic [8:0]      gen_x,
  input  logic [9:0]      gen_y,
  input  logic            key_valid,
  input  logic [7:0]      key_ch,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_active,
  output logic [7:0]      rd_ch,
  output logic [8:0]      rd_x,
  output logic [9:0]      rd_y,
  output logic            hit,
  output logic            miss,
  output logic [15:0]     score,
  output logic [7:0]      miss_cnt,
  output logic            pool_full
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_SPAWN = 2'd2;

  localparam int              CW       = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CW-1:0]   SP_LAST  = CW'(SPAWN_PERIOD - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(SLOTS - 1);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] sweep_idx_q, sweep_idx_d;
  logic [CW-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic            key_pend_q, key_pend_d;
  logic [7:0]      key_ch_q, key_ch_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  logic [15:0]     score_q, score_d;
  logic [7:0]      miss_cnt_q, miss_cnt_d;
  logic            pool_full_q, pool_full_d;

  logic [SLOTS-1:0]       s_active, s_over, s_match;
  logic [SLOTS-1:0]       sweep_sel, ld_sel, clr_sel;
  logic [SLOTS-1:0][7:0]  s_ch;
  logic [SLOTS-1:0][8:0]  s_x;
  logic [SLOTS-1:0][9:0]  s_y;

  logic [7:0]      res_ch;
  logic [3:0]      spawn_speed;
  logic            best_found, free_found;
  logic [IDXW-1:0] best_idx, free_idx;
  logic [8:0]      best_x;

  // A key arriving in IDLE is newer than any buffered one, so it takes priority.
  assign res_ch = key_valid ? key_ch : key_ch_q;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    letter_pool_slot #(.X_MAX(X_MAX)) u_slot (
      .clk      (clk),
      .clrn     (clrn),
      .sweep_en (sweep_sel[g]),
      .ld_en    (ld_sel[g]),
      .clr_en   (clr_sel[g]),
      .ld_ch    (gen_ch),
      .ld_speed (spawn_speed),
      .ld_x     (gen_x),
      .ld_y     (gen_y),
      .key_ch   (res_ch),
      .active   (s_active[g]),
      .ch       (s_ch[g]),
      .x        (s_x[g]),
      .y        (s_y[g]),
      .over     (s_over[g]),
      .match    (s_match[g])
    );
  end

  // Strict '>' keeps the lowest index on equal x.
  always_comb begin
    best_found = 1'b0;
    best_idx   = '0;
    best_x     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (s_match[i] && (!best_found || (s_x[i] > best_x))) begin
        best_found = 1'b1;
        best_idx   = IDXW'(i);
        best_x     = s_x[i];
      end
      if (!s_active[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    spawn_cnt_d = spawn_cnt_q;
    key_pend_d  = key_pend_q;
    key_ch_d    = key_ch_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    score_d     = score_q;
    miss_cnt_d  = miss_cnt_q;
    sweep_sel   = '0;
    ld_sel      = '0;
    clr_sel     = '0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
          if (key_valid) begin
            key_pend_d = 1'b1;
            key_ch_d   = key_ch;
          end
        end else if (key_valid || key_pend_q) begin
          key_pend_d = 1'b0;
          if (best_found) begin
            clr_sel[best_idx] = 1'b1;
            hit_d             = 1'b1;
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          end
        end
      end
      ST_SWEEP: begin
        sweep_sel[sweep_idx_q] = 1'b1;
        if (s_over[sweep_idx_q]) begin
          miss_d = 1'b1;
          if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
        end
        if (sweep_idx_q == IDX_LAST) state_d = ST_SPAWN;
        else                         sweep_idx_d = sweep_idx_q + 1'b1;
      end
      ST_SPAWN: begin
        state_d = ST_IDLE;
        if (spawn_cnt_q == SP_LAST) begin
          spawn_cnt_d = '0;
          if (free_found) ld_sel[free_idx] = 1'b1;
        end else begin
          spawn_cnt_d = spawn_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && key_valid) begin
      key_pend_d = 1'b1;
      key_ch_d   = key_ch;
    end
  end

  assign pool_full_d = &s_active;

`ifdef LETTER_POOL_RAMP_EN
  logic [1:0] level_q, level_d;
  logic [3:0] hit_mod_q, hit_mod_d;
  logic [4:0] spd_sum;

  always_comb begin
    level_d   = level_q;
    hit_mod_d = hit_mod_q;
    if (hit_d) begin
      hit_mod_d = hit_mod_q + 4'd1;
      if ((hit_mod_q == 4'hF) && (level_q != 2'd3)) level_d = level_q + 2'd1;
    end
    spd_sum     = {1'b0, gen_speed} + {3'b0, level_q};
    spawn_speed = (spd_sum > 5'd15) ? 4'hF : spd_sum[3:0];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      level_q   <= '0;
      hit_mod_q <= '0;
    end else begin
      level_q   <= level_d;
      hit_mod_q <= hit_mod_d;
    end
  end
`else
  assign spawn_speed = gen_speed;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      sweep_idx_q <= '0;
      spawn_cnt_q <= '0;
      key_pend_q  <= 1'b0;
      key_ch_q    <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      miss_cnt_q  <= '0;
      pool_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      spawn_cnt_q <= spawn_cnt_d;
      key_pend_q  <= key_pend_d;
      key_ch_q    <= key_ch_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      score_q     <= score_d;
      miss_cnt_q  <= miss_cnt_d;
      pool_full_q <= pool_full_d;
    end
  end

  assign rd_active = s_active[rd_idx];
  assign rd_ch     = s_ch[rd_idx];
  assign rd_x      = s_x[rd_idx];
  assign rd_y      = s_y[rd_idx];
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign miss_cnt  = miss_cnt_q;
  assign pool_full = pool_full_q;
endmodule

// File: tb/tb_letter_pool.sv
// Bench for letter_pool: vector table of ticks/keys against a behavioural pool model,
// with a hit/miss event scoreboard and hand-timed sequences for buffered keys and reset.
module tb_letter_pool;
  localparam int SLOTS = 8;
  localparam byte EV_H = 8'd1;
  localparam byte EV_M = 8'd2;

  logic        clk = 1'b0;
  logic        clrn;
  logic        frame_tick, key_valid;
  logic [7:0]  gen_ch, key_ch;
  logic [3:0]  gen_speed;
  logic [8:0]  gen_x;
  logic [9:0]  gen_y;
  logic [2:0]  rd_idx;
  logic        rd_active, hit, miss, pool_full;
  logic [7:0]  rd_ch, miss_cnt;
  logic [8:0]  rd_x;
  logic [9:0]  rd_y;
  logic [15:0] score;

  letter_pool #(.SLOTS(8), .IDXW(3), .X_MAX(480), .SPAWN_PERIOD(1)) dut (
    .clk(clk), .clrn(clrn), .frame_tick(frame_tick),
    .gen_ch(gen_ch), .gen_speed(gen_speed), .gen_x(gen_x), .gen_y(gen_y),
    .key_valid(key_valid), .key_ch(key_ch), .rd_idx(rd_idx),
    .rd_active(rd_active), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
    .hit(hit), .miss(miss), .score(score), .miss_cnt(miss_cnt), .pool_full(pool_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic       m_act [SLOTS];
  logic [7:0] m_ch  [SLOTS];
  logic [8:0] m_x   [SLOTS];
  logic [9:0] m_y   [SLOTS];
  logic [3:0] m_spd [SLOTS];
  int         m_score, m_miss;
  byte        exp_q[$];
  byte        mon_ev;

  typedef struct {
    bit          is_key;
    logic [7:0]  ch;
    logic [3:0]  spd;
    logic [8:0]  x;
    logic [9:0]  y;
    logic [15:0] e_score;
    logic [7:0]  e_miss;
    logic        e_full;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) m_act[i] = 1'b0;
    m_score = 0;
    m_miss  = 0;
    exp_q.delete();
  endtask

  task automatic model_tick(input logic [7:0] ch, input logic [3:0] spd,
                            input logic [8:0] x, input logic [9:0] y);
    bit placed;
    for (int i = 0; i < SLOTS; i++) begin
      if (m_act[i]) begin
        int s;
        s = int'(m_x[i]) + int'(m_spd[i]);
        if (s >= 480) begin
          m_act[i] = 1'b0;
          m_miss++;
          exp_q.push_back(EV_M);
        end else m_x[i] = s[8:0];
      end
    end
    placed = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!m_act[i] && !placed) begin
        placed = 1'b1;
        m_act[i] = 1'b1; m_ch[i] = ch; m_spd[i] = spd; m_x[i] = x; m_y[i] = y;
      end
    end
  endtask

  task automatic model_key(input logic [7:0] k);
    int best;
    best = -1;
    for (int i = 0; i < SLOTS; i++)
      if (m_act[i] && m_ch[i] == k && (best < 0 || m_x[i] > m_x[best])) best = i;
    if (best >= 0) begin
      m_act[best] = 1'b0;
      m_score++;
      exp_q.push_back(EV_H);
    end
  endtask

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic do_tick(input logic [7:0] ch, input logic [3:0] spd,
                         input logic [8:0] x, input logic [9:0] y);
    gen_ch = ch; gen_speed = spd; gen_x = x; gen_y = y;
    model_tick(ch, spd, x, y);
    frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_key(input logic [7:0] k);
    model_key(k);
    key_ch = k; key_valid = 1'b1;
    @(posedge clk); #1 key_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_slots(input string tag);
    for (int i = 0; i < SLOTS; i++) begin
      rd_idx = 3'(i);
      #1;
      if (m_act[i])
        chk($sformatf("%s_slot%0d", tag, i), 64'({rd_active, rd_ch, rd_x, rd_y}),
            64'({1'b1, m_ch[i], m_x[i], m_y[i]}));
      else
        chk($sformatf("%s_slot%0d_free", tag, i), 64'(rd_active), 64'd0);
    end
    chk({tag, "_events_left"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_score"}, 64'(score), 64'd0);
    chk({tag, "_miss_cnt"}, 64'(miss_cnt), 64'd0);
    chk({tag, "_hit_miss"}, 64'({hit, miss}), 64'd0);
    chk({tag, "_pool_full"}, 64'(pool_full), 64'd0);
    for (int i = 0; i < SLOTS; i++) begin
      rd_idx = 3'(i);
      #0.1;
      chk($sformatf("%s_slot%0d", tag, i), 64'({rd_active, rd_ch, rd_x, rd_y}), 64'd0);
    end
  endtask

  // Scoreboard: every hit/miss pulse cycle consumes one expected event.
  always @(negedge clk) begin
    if (clrn === 1'b1 && (hit || miss)) begin
      checks++;
      if (hit && miss) begin
        fails++;
        $display("FAIL hit_miss_overlap actual=11 expected=one_of");
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse actual hit=%0d miss=%0d expected=none", hit, miss);
      end else begin
        mon_ev = exp_q.pop_front();
        if (!((mon_ev == EV_H && hit) || (mon_ev == EV_M && miss))) begin
          fails++;
          $display("FAIL pulse_kind actual hit=%0d miss=%0d expected_ev=%0d", hit, miss, mon_ev);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           key  ch     spd   x       y        score  miss  full
    tbl[0]  = '{1'b0, 8'h61, 4'd2,  9'd0,   10'd100, 16'd0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 8'h62, 4'd3,  9'd10,  10'd200, 16'd0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 8'h61, 4'd12, 9'd470, 10'd5,   16'd0, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 8'h63, 4'd1,  9'd0,   10'd7,   16'd0, 8'd1, 1'b0};
    tbl[4]  = '{1'b1, 8'h61, 4'd0,  9'd0,   10'd0,   16'd1, 8'd1, 1'b0};
    tbl[5]  = '{1'b0, 8'h61, 4'd1,  9'd40,  10'd1,   16'd1, 8'd1, 1'b0};
    tbl[6]  = '{1'b0, 8'h64, 4'd1,  9'd0,   10'd0,   16'd1, 8'd1, 1'b0};
    tbl[7]  = '{1'b0, 8'h61, 4'd1,  9'd90,  10'd2,   16'd1, 8'd1, 1'b0};
    tbl[8]  = '{1'b1, 8'h61, 4'd0,  9'd0,   10'd0,   16'd2, 8'd1, 1'b0};
    tbl[9]  = '{1'b0, 8'h61, 4'd1,  9'd43,  10'd3,   16'd2, 8'd1, 1'b0};
    tbl[10] = '{1'b1, 8'h61, 4'd0,  9'd0,   10'd0,   16'd3, 8'd1, 1'b0};
    tbl[11] = '{1'b1, 8'h7A, 4'd0,  9'd0,   10'd0,   16'd3, 8'd1, 1'b0};

    clrn = 1'b0; frame_tick = 1'b0; key_valid = 1'b0; key_ch = '0;
    gen_ch = '0; gen_speed = '0; gen_x = '0; gen_y = '0; rd_idx = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    clrn = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 12; v++) begin
      if (tbl[v].is_key) do_key(tbl[v].ch);
      else do_tick(tbl[v].ch, tbl[v].spd, tbl[v].x, tbl[v].y);
      chk($sformatf("v%0d_score", v), 64'(score), 64'(tbl[v].e_score));
      chk($sformatf("v%0d_miss_cnt", v), 64'(miss_cnt), 64'(tbl[v].e_miss));
      chk($sformatf("v%0d_pool_full", v), 64'(pool_full), 64'(tbl[v].e_full));
      check_slots($sformatf("v%0d", v));
    end

    // Fill the pool, then keep spawning: nothing may be overwritten.
    for (int n = 0; n < 4; n++) do_tick(8'h65, 4'd1, 9'd0, 10'(300 + n));
    chk("fill_pool_full", 64'(pool_full), 64'd1);
    for (int n = 0; n < 2; n++) do_tick(8'h66, 4'd1, 9'd0, 10'd400);
    chk("full_still_full", 64'(pool_full), 64'd1);
    check_slots("full");
    do_key(8'h62);
    chk("freed_pool_full", 64'(pool_full), 64'd0);
    chk("freed_score", 64'(score), 64'(m_score));
    check_slots("freed");

    // Key arriving on the second sweep cycle is resolved after SPAWN.
    gen_ch = 8'h66; gen_speed = 4'd1; gen_x = 9'd0; gen_y = 10'd9;
    model_tick(8'h66, 4'd1, 9'd0, 10'd9);
    model_key(8'h65);
    frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 key_ch = 8'h65; key_valid = 1'b1;
    @(posedge clk); #1 key_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("buffered_key_not_early", 64'(hit), 64'd0);
    @(posedge clk);
    #1 chk("buffered_key_hit_after_spawn", 64'(hit), 64'd1);
    @(posedge clk);
    #1 chk("buffered_key_hit_one_cycle", 64'(hit), 64'd0);
    chk("buffered_score", 64'(score), 64'(m_score));
    check_slots("buffered");

    // Asynchronous reset in the middle of a sweep.
    gen_ch = 8'h67;
    frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b0;
    #1 check_reset_state("mid_sweep_reset");
    model_clear();
    @(posedge clk); #1 clrn = 1'b1;
    @(posedge clk); #1;

    // X_MAX boundary: landing exactly on 480 is a miss, 479 is not.
    do_tick(8'h67, 4'd10, 9'd470, 10'd11);
    do_tick(8'h68, 4'd10, 9'd469, 10'd12);
    chk("edge480_miss_cnt", 64'(miss_cnt), 64'(m_miss));
    do_tick(8'h69, 4'd1, 9'd0, 10'd13);
    chk("edge479_miss_cnt", 64'(miss_cnt), 64'(m_miss));
    check_slots("edge479");
    do_tick(8'h6A, 4'd1, 9'd0, 10'd14);
    chk("edge_final_miss_cnt", 64'(miss_cnt), 64'd2);
    chk("edge_final_score", 64'(score), 64'd0);
    check_slots("edge_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
